pwm_multi: RTL

- Parametrised, multi-channel successor to the single-channel free-running PWM.
- NCH channels share one programmable-period counter. Each channel has its own double-buffered duty register, written through a valid/ready port.
- Supports edge-aligned and center-aligned modes and a per-channel output polarity.
- Sits between the switch/register front-end and LED/motor pins, and replaces the fixed-period, switch-decoded duty comparator.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_multi_if.sv | 19 +
 rtl/pwm_chan.sv | 35 +++
 rtl/pwm_multi.sv | 89 ++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: counting modes, counter
// direction and the channel-index width helper.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    // Channel select needs at least one bit even for a single channel.
    function automatic int chan_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Duty-write port of pwm_multi: valid/ready handshake carrying a channel
// select and a new duty value.
interface pwm_multi_if #(
    parameter int CBITS = 19,
    parameter int NCH   = 4
);
    import pwm_pkg::*;

    localparam int CHW = chan_w(NCH);

    logic             wr_valid;
    logic             wr_ready;
    logic [CHW-1:0]   wr_ch;
    logic [CBITS-1:0] wr_duty;

    modport master (output wr_valid, wr_ch, wr_duty, input wr_ready);
    modport slave  (input wr_valid, wr_ch, wr_duty, output wr_ready);

endinterface

// File: rtl/pwm_chan.sv
// One PWM channel: double-buffered duty (shadow -> active on load) and a
// registered compare against the shared counter with output polarity.
module pwm_chan #(
    parameter int   CBITS = 19,
    parameter logic POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_en,
    input  logic             load,
    input  logic [CBITS-1:0] wr_duty,
    input  logic [CBITS-1:0] cnt,
    output logic             pwm_out
);

    logic [CBITS-1:0] shadow;
    logic [CBITS-1:0] active;

    // load samples the old shadow, so a write in the same cycle waits a period
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            active  <= '0;
            pwm_out <= POL;
        end else begin
            if (wr_en)
                shadow <= wr_duty;
            if (load)
                active <= shadow;
            pwm_out <= (en && (cnt < active)) ^ POL;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared edge/center-aligned period counter driving
// NCH double-buffered duty comparators, duties written over a valid/ready port.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int             CBITS = 19,
    parameter int             NCH   = 4,
    parameter logic [NCH-1:0] POL   = {NCH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [CBITS-1:0] period,
    pwm_multi_if.slave       wr,
    output logic [NCH-1:0]   pwm_out,
    output logic             period_start
);

    localparam int CHW = chan_w(NCH);

    logic [CBITS-1:0] cnt;
    logic [CBITS-1:0] per_act;
    logic             mode_act;
    dir_t             dir;
    logic             term;
    logic             load;
    logic             wr_acc;

    // per_act==1 in center mode never sees dir==DOWN at cnt==1, so it is
    // treated as terminal directly (sequence 0,1).
    always_comb begin
        term = 1'b0;
        if (per_act == '0)
            term = 1'b1;
        else if (mode_act == MODE_EDGE)
            term = (cnt == per_act);
        else
            term = (cnt == CBITS'(1)) && ((dir == DIR_DOWN) || (per_act == CBITS'(1)));
    end

    assign load   = !en || term;
    assign wr_acc = wr.wr_valid && wr.wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            dir          <= DIR_UP;
            per_act      <= '0;
            mode_act     <= MODE_EDGE;
            period_start <= 1'b0;
            wr.wr_ready  <= 1'b0;
        end else begin
            wr.wr_ready  <= 1'b1;
            // cnt==0 only ever occurs on the first cycle of a period
            period_start <= en && (cnt == '0);
            if (load) begin
                cnt      <= '0;
                dir      <= DIR_UP;
                per_act  <= period;
                mode_act <= mode;
            end else if ((mode_act == MODE_CENTER) &&
                         ((dir == DIR_DOWN) || (cnt == per_act))) begin
                dir <= DIR_DOWN;
                cnt <= cnt - CBITS'(1);
            end else begin
                cnt <= cnt + CBITS'(1);
            end
        end
    end

    // Out-of-range channel codes match no instance and are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_chan #(
            .CBITS (CBITS),
            .POL   (POL[i])
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .wr_en   (wr_acc && (wr.wr_ch == CHW'(i))),
            .load    (load),
            .wr_duty (wr.wr_duty),
            .cnt     (cnt),
            .pwm_out (pwm_out[i])
        );
    end

endmodule
